hazard_scoreboard: RTL and testbench

//  Backward-flowing control for the 5-stage pipeline: tracks in-flight register writes from
//  ID->EX issue to WB retire and drives stall/bubble/flush to the IF/ID and ID/EX registers.

---
 rtl/riscv_pipe_pkg.sv | 10 +
 rtl/hazard_scoreboard_if.sv | 39 +++
 rtl/sb_counter.sv | 37 +++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the 5-stage RISC-V pipeline.
package riscv_pipe_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] X0        = '0;
    localparam logic [31:0]           NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue/squash/retire inputs and stall/flush outputs between the pipeline and the scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned PERF_W = 32
) ();
    import riscv_pipe_pkg::*;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_RegWrite;
    logic                  ex_branch_taken;
    logic                  ex_RegWrite;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  wb_RegWrite;
    logic [REG_ADDR_W-1:0] wb_rd_addr;

    logic                  stall_if;
    logic                  stall_id;
    logic                  bubble_ex;
    logic                  flush_id;
    logic                  sb_error;
    logic [PERF_W-1:0]     stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd_addr, id_RegWrite,
        output ex_branch_taken, ex_RegWrite, ex_rd_addr, wb_RegWrite, wb_rd_addr,
        input  stall_if, stall_id, bubble_ex, flush_id, sb_error, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd_addr, id_RegWrite,
        input  ex_branch_taken, ex_RegWrite, ex_rd_addr, wb_RegWrite, wb_rd_addr,
        output stall_if, stall_id, bubble_ex, flush_id, sb_error, stall_cycles
    );

endinterface

// File: rtl/sb_counter.sv
// Per-register pending-write counter; saturates at both ends and pulses err when it would wrap.
module sb_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             err
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   net;

    // One extra bit: the MSB is set exactly when the step would underflow or overflow.
    always_comb begin
        net     = {1'b0, count_q} + {{CNT_W{1'b0}}, inc} - {{CNT_W{1'b0}}, dec};
        count_d = net[CNT_W-1:0];
        err     = 1'b0;
        if (net[CNT_W]) begin
            count_d = count_q;
            err     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard for a non-forwarding 5-stage pipe: stalls ID on RAW against
// in-flight writes and flushes IF/ID on taken branches.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS  = riscv_pipe_pkg::NUM_REGS,
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned PERF_W    = 32
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    import riscv_pipe_pkg::*;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            cnt_err;

    logic raw_stall;
    logic issue;
    logic squash;
    logic retire;
    logic ex_younger;

    logic stall_if, stall_id, bubble_ex, flush_id;
    logic              sb_error_q;
    logic [PERF_W-1:0] stall_cycles_q;

    function automatic logic pend(input logic [REG_ADDR_W-1:0] r,
                                  input logic [CNT_W-1:0]      c,
                                  input logic                  wb_we,
                                  input logic [REG_ADDR_W-1:0] wb_rd);
        logic wb_hit;
        wb_hit = WB_BYPASS && wb_we && (wb_rd == r) && (c == CNT_W'(1));
        return (r != X0) && (c != '0) && !wb_hit;
    endfunction

    always_comb begin
        raw_stall = bus.id_valid &&
            ((bus.id_use_rs1 &&
              pend(bus.id_rs1, cnt[bus.id_rs1], bus.wb_RegWrite, bus.wb_rd_addr)) ||
             (bus.id_use_rs2 &&
              pend(bus.id_rs2, cnt[bus.id_rs2], bus.wb_RegWrite, bus.wb_rd_addr)));
    end

    // The branch in EX is itself the squasher, so the EX instruction is never younger.
    assign ex_younger = 1'b0;

    assign issue  = bus.id_valid && bus.id_RegWrite && (bus.id_rd_addr != X0) &&
                    !raw_stall && !bus.ex_branch_taken;
    assign squash = bus.ex_branch_taken && bus.ex_RegWrite && (bus.ex_rd_addr != X0) &&
                    ex_younger;
    assign retire = bus.wb_RegWrite && (bus.wb_rd_addr != X0);

    assign cnt[0]     = '0;
    assign cnt_err[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc, dec;
        assign inc = issue && (bus.id_rd_addr == REG_ADDR_W'(r));
        assign dec = (retire && (bus.wb_rd_addr == REG_ADDR_W'(r))) ||
                     (squash && (bus.ex_rd_addr == REG_ADDR_W'(r)));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc),
            .dec   (dec),
            .count (cnt[r]),
            .err   (cnt_err[r])
        );
    end

    // Flush wins over stall: the stalled ID instruction is wrong-path anyway.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        if (bus.ex_branch_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (raw_stall) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_error_q     <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            if (|cnt_err) begin
                sb_error_q <= 1'b1;
            end
            if (raw_stall && !bus.ex_branch_taken && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            end
        end
    end

    assign bus.stall_if     = stall_if;
    assign bus.stall_id     = stall_id;
    assign bus.bubble_ex    = bubble_ex;
    assign bus.flush_id     = flush_id;
    assign bus.sb_error     = sb_error_q;
    assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, RAW stalls, multi-write, branch flush, x0 and error.
module tb_hazard_scoreboard;
    import riscv_pipe_pkg::*;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    hazard_scoreboard_if #(.PERF_W(32)) bus ();

    hazard_scoreboard #(
        .NUM_REGS  (32),
        .CNT_W     (2),
        .WB_BYPASS (1'b1),
        .PERF_W    (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic sif, input logic sid,
                           input logic bex, input logic fid);
        chk({tag, ".stall_if"},  {31'd0, bus.stall_if},  {31'd0, sif});
        chk({tag, ".stall_id"},  {31'd0, bus.stall_id},  {31'd0, sid});
        chk({tag, ".bubble_ex"}, {31'd0, bus.bubble_ex}, {31'd0, bex});
        chk({tag, ".flush_id"},  {31'd0, bus.flush_id},  {31'd0, fid});
    endtask

    task automatic clr();
        bus.id_valid        = 1'b0;
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_use_rs1      = 1'b0;
        bus.id_use_rs2      = 1'b0;
        bus.id_rd_addr      = '0;
        bus.id_RegWrite     = 1'b0;
        bus.ex_branch_taken = 1'b0;
        bus.ex_RegWrite     = 1'b0;
        bus.ex_rd_addr      = '0;
        bus.wb_RegWrite     = 1'b0;
        bus.wb_rd_addr      = '0;
    endtask

    task automatic issue(input logic [4:0] rd);
        clr();
        bus.id_valid    = 1'b1;
        bus.id_RegWrite = 1'b1;
        bus.id_rd_addr  = rd;
    endtask

    task automatic read_rs1(input logic [4:0] rs);
        clr();
        bus.id_valid   = 1'b1;
        bus.id_use_rs1 = 1'b1;
        bus.id_rs1     = rs;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        clr();
        #12;
        chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.sb_error", {31'd0, bus.sb_error}, 32'd0);
        chk("rst.stall_cycles", bus.stall_cycles, 32'd0);
        cyc();
        reset = 1'b1;

        // Mid-run reset with x5 reserved twice and a sticky error set.
        issue(5'd5);
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = 5'd4;
        #1 chk_out("t1.issue", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        issue(5'd5);
        #1 chk("t1.err_set", {31'd0, bus.sb_error}, 32'd1);
        cyc();
        read_rs1(5'd5);
        #1 chk_out("t1.stall", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        #1 chk("t1.cycles1", bus.stall_cycles, 32'd1);
        reset = 1'b0;
        #1 chk_out("t1.async", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1.cycles0", bus.stall_cycles, 32'd0);
        chk("t1.err0", {31'd0, bus.sb_error}, 32'd0);
        cyc();
        reset = 1'b1;
        #1 chk_out("t1.cleared", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // RAW on x5 released by a bypassed WB retire.
        issue(5'd5);
        #1 chk_out("t2.issue", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        read_rs1(5'd5);
        for (int i = 0; i < 3; i++) begin
            #1 chk_out("t2.stall", 1'b1, 1'b1, 1'b1, 1'b0);
            cyc();
        end
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = 5'd5;
        #1 chk_out("t2.wb_bypass", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2.cycles3", bus.stall_cycles, 32'd3);
        cyc();
        read_rs1(5'd5);
        #1 chk_out("t2.released", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Two writes to x7 in flight; only the second retire frees it.
        issue(5'd7);
        cyc();
        issue(5'd7);
        cyc();
        clr();
        bus.id_valid   = 1'b1;
        bus.id_use_rs2 = 1'b1;
        bus.id_rs2     = 5'd7;
        #1 chk_out("t3.stall_cnt2", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = 5'd7;
        #1 chk_out("t3.first_wb", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        bus.wb_RegWrite = 1'b0;
        #1 chk_out("t3.stall_cnt1", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        bus.wb_RegWrite = 1'b1;
        #1 chk_out("t3.second_wb", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        bus.wb_RegWrite = 1'b0;
        #1 chk_out("t3.free", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3.cycles6", bus.stall_cycles, 32'd6);
        cyc();

        // Same-cycle issue and retire on x9 leaves one reservation.
        issue(5'd9);
        cyc();
        issue(5'd9);
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = 5'd9;
        #1 chk_out("t4.issue_retire", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        read_rs1(5'd9);
        #1 chk_out("t4.still_pend", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = 5'd9;
        #1 chk_out("t4.retire", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();

        // Taken branch while ID stalls on x3 and wants to write x6.
        issue(5'd3);
        cyc();
        read_rs1(5'd3);
        bus.id_RegWrite = 1'b1;
        bus.id_rd_addr  = 5'd6;
        #1 chk_out("t5.stall", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        bus.ex_branch_taken = 1'b1;
        bus.ex_RegWrite     = 1'b1;
        bus.ex_rd_addr      = 5'd3;
        #1 chk_out("t5.flush", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5.cycles8", bus.stall_cycles, 32'd8);
        cyc();
        read_rs1(5'd6);
        #1 chk_out("t5.no_resv_x6", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5.cycles_hold", bus.stall_cycles, 32'd8);
        cyc();
        read_rs1(5'd3);
        #1 chk_out("t5.x3_kept", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = 5'd3;
        #1 chk_out("t5.x3_retire", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5.cycles9", bus.stall_cycles, 32'd9);
        cyc();

        // x0 is never reserved; retire of idle x4 sets the sticky error.
        issue(X0);
        bus.id_use_rs1 = 1'b1;
        bus.id_use_rs2 = 1'b1;
        #1 chk_out("t6.x0_issue", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6.err_clean", {31'd0, bus.sb_error}, 32'd0);
        cyc();
        read_rs1(X0);
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = X0;
        #1 chk_out("t6.x0_read", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc();
        clr();
        bus.wb_RegWrite = 1'b1;
        bus.wb_rd_addr  = 5'd4;
        #1 chk("t6.x0_no_err", {31'd0, bus.sb_error}, 32'd0);
        cyc();
        clr();
        #1 chk("t6.err_set", {31'd0, bus.sb_error}, 32'd1);
        cyc();
        cyc();
        chk("t6.err_sticky", {31'd0, bus.sb_error}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
